// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite memory slave.
// Provides bus widths, AXI response codes, the channel-level typedefs, the slave
// FSM state encoding, and the read/write arbitration record used to alternate
// grants when both address channels request in the same cycle.
package axi_lite_pkg;

   localparam int ADDR_WIDTH = 12;
   localparam int DATA_WIDTH = 32;
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int MEM_WORDS  = 1024;

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [STRB_WIDTH-1:0] strb_t;
   typedef logic [1:0]            resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WADDR = 3'd3,
      WDATA = 3'd4,
      WRESP = 3'd5
   } state_type;

   // Which direction won the most recently completed transaction.
   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_type;

endpackage

// File: rtl/axi_lite_mem_array.sv
// Single-port word memory with byte-enable writes and a registered read.
// Ports:
//   aclk, areset_n : clock and asynchronous active-low reset (read register only)
//   idx            : word index shared by read and write
//   wr_en/wr_strb/wr_data : byte-enable write, applied on the rising edge
//   rd_en          : load the read register from mem[idx]
//   rd_clr         : load the read register with zero (error responses)
//   rd_data        : registered read data, held until the next rd_en/rd_clr
// The storage array itself is never reset; only the read register is.
module axi_lite_mem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int IDX_WIDTH  = $clog2(MEM_WORDS)
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   input  logic [IDX_WIDTH-1:0]    idx,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   input  logic                    rd_clr,
   output logic [DATA_WIDTH-1:0]   rd_data
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem_r [0:MEM_WORDS-1];
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Byte-enable write into the storage array.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
         if (wr_en && wr_strb[i]) begin
            mem_r[idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Read register: cleared for error responses, otherwise holds between loads.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_clr) begin
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
         rd_data_r <= mem_r[idx];
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave endpoint in front of a word-organised memory.
// Serves one transaction at a time. When AR and AW request together in IDLE the
// grant goes to the direction that did not win last time (read wins after reset).
// Ports:
//   aclk, areset_n              : clock, asynchronous active-low reset
//   ar_addr/ar_valid/ar_ready   : read address channel
//   r_data/r_resp/r_valid/r_ready : read data channel
//   aw_addr/aw_valid/aw_ready   : write address channel
//   w_data/w_strb/w_valid/w_ready : write data channel
//   b_resp/b_valid/b_ready      : write response channel
// Responses: misaligned address -> SLVERR, index beyond MEM_WORDS -> DECERR,
// both with zero read data and no memory update; otherwise OKAY.
// All handshake outputs are registered and decoded from the next FSM state.
module axi_lite_slave_mem #(
   parameter int ADDR_WIDTH = axi_lite_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = axi_lite_pkg::DATA_WIDTH,
   parameter int MEM_WORDS  = axi_lite_pkg::MEM_WORDS
) (
   input  logic                    aclk,
   input  logic                    areset_n,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_valid,
   input  logic                    r_ready,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready
);

   import axi_lite_pkg::*;

   localparam int MEM_IDX_WIDTH = $clog2(MEM_WORDS);

   state_type                state_r;
   state_type                state_next_s;
   grant_type                last_grant_r;
   logic [ADDR_WIDTH-1:0]    addr_r;
   logic [1:0]               r_resp_r;
   logic [1:0]               b_resp_r;
   logic                     ar_ready_r;
   logic                     r_valid_r;
   logic                     aw_ready_r;
   logic                     w_ready_r;
   logic                     b_valid_r;
   logic [1:0]               rd_resp_s;
   logic [1:0]               wr_resp_s;
   logic                     r_done_s;
   logic                     w_done_s;
   logic                     b_done_s;
   logic [MEM_IDX_WIDTH-1:0] mem_idx_s;
   logic                     mem_rd_en_s;
   logic                     mem_rd_clr_s;
   logic                     mem_wr_en_s;
   logic [DATA_WIDTH-1:0]    mem_rd_data_s;

   // Classify an address: alignment first, then range.
   function automatic logic [1:0] resp_decode(input logic [ADDR_WIDTH-1:0] addr);
      logic [31:0] idx_wide;
      idx_wide = 32'(addr[ADDR_WIDTH-1:2]);
      if (addr[1:0] != 2'b00) begin
         resp_decode = RESP_SLVERR;
      end else if (idx_wide >= 32'(MEM_WORDS)) begin
         resp_decode = RESP_DECERR;
      end else begin
         resp_decode = RESP_OKAY;
      end
   endfunction

   // Handshake completions and address classification for the active transaction.
   always_comb begin
      r_done_s  = r_valid_r && r_ready;
      w_done_s  = (state_r == WDATA) && w_valid && w_ready_r;
      b_done_s  = b_valid_r && b_ready;
      rd_resp_s = resp_decode(ar_addr);
      wr_resp_s = resp_decode(addr_r);
   end

   // Next-state logic, including the alternating grant when AR and AW collide.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (ar_valid && aw_valid) begin
               if (last_grant_r == GRANT_WRITE) begin
                  state_next_s = RADDR;
               end else begin
                  state_next_s = WADDR;
               end
            end else if (ar_valid) begin
               state_next_s = RADDR;
            end else if (aw_valid) begin
               state_next_s = WADDR;
            end else begin
               state_next_s = IDLE;
            end
         end
         RADDR: state_next_s = RDATA;
         RDATA: begin
            if (r_done_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RDATA;
            end
         end
         WADDR: state_next_s = WDATA;
         WDATA: begin
            if (w_done_s) begin
               state_next_s = WRESP;
            end else begin
               state_next_s = WDATA;
            end
         end
         WRESP: begin
            if (b_done_s) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = WRESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Memory port control: reads use the live AR address during RADDR so the
   // registered read data is ready on entry to RDATA; writes use the captured AW address.
   always_comb begin
      if (state_r == RADDR) begin
         mem_idx_s = ar_addr[MEM_IDX_WIDTH+1:2];
      end else begin
         mem_idx_s = addr_r[MEM_IDX_WIDTH+1:2];
      end
      mem_rd_en_s  = (state_r == RADDR) && (rd_resp_s == RESP_OKAY);
      mem_rd_clr_s = (state_r == RADDR) && (rd_resp_s != RESP_OKAY);
      mem_wr_en_s  = w_done_s && (wr_resp_s == RESP_OKAY);
   end

   // State, arbitration history, captured address, responses and registered handshakes.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_r      <= IDLE;
         last_grant_r <= GRANT_WRITE;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         r_resp_r     <= RESP_OKAY;
         b_resp_r     <= RESP_OKAY;
         ar_ready_r   <= 1'b0;
         r_valid_r    <= 1'b0;
         aw_ready_r   <= 1'b0;
         w_ready_r    <= 1'b0;
         b_valid_r    <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         ar_ready_r <= (state_next_s == RADDR);
         r_valid_r  <= (state_next_s == RDATA);
         aw_ready_r <= (state_next_s == WADDR);
         w_ready_r  <= (state_next_s == WDATA);
         b_valid_r  <= (state_next_s == WRESP);

         if (state_r == RADDR) begin
            addr_r   <= ar_addr;
            r_resp_r <= rd_resp_s;
         end else if (state_r == WADDR) begin
            addr_r <= aw_addr;
         end else begin
            addr_r <= addr_r;
         end

         if (w_done_s) begin
            b_resp_r <= wr_resp_s;
         end else begin
            b_resp_r <= b_resp_r;
         end

         if (r_done_s) begin
            last_grant_r <= GRANT_READ;
         end else if (b_done_s) begin
            last_grant_r <= GRANT_WRITE;
         end else begin
            last_grant_r <= last_grant_r;
         end
      end
   end

   axi_lite_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .IDX_WIDTH  (MEM_IDX_WIDTH)
   ) u_mem (
      .aclk     (aclk),
      .areset_n (areset_n),
      .idx      (mem_idx_s),
      .wr_en    (mem_wr_en_s),
      .wr_strb  (w_strb),
      .wr_data  (w_data),
      .rd_en    (mem_rd_en_s),
      .rd_clr   (mem_rd_clr_s),
      .rd_data  (mem_rd_data_s)
   );

   assign ar_ready = ar_ready_r;
   assign r_valid  = r_valid_r;
   assign r_data   = mem_rd_data_s;
   assign r_resp   = r_resp_r;
   assign aw_ready = aw_ready_r;
   assign w_ready  = w_ready_r;
   assign b_valid  = b_valid_r;
   assign b_resp   = b_resp_r;

endmodule
